// File: rtl/ising_lattice_sweeper.sv
// Spin store and raster sequencer for the Metropolis Ising core: holds an LxL periodic
// lattice, presents each site with its four neighbours and a random word, and writes back the result.
module ising_lattice_sweeper #(
    parameter int          SIDE_LOG2 = 3,
    parameter int          INIT_SPIN = 1,
    parameter logic [31:0] SEED      = 32'hACE12468
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [15:0]                   num_sweeps,
    input  logic                          wr_en,
    input  logic [SIDE_LOG2-1:0]          wr_x,
    input  logic [SIDE_LOG2-1:0]          wr_y,
    input  logic                          wr_spin,
    input  logic [SIDE_LOG2-1:0]          rd_x,
    input  logic [SIDE_LOG2-1:0]          rd_y,
    output logic                          rd_spin,
    output logic                          spin_val,
    output logic                          left,
    output logic                          right,
    output logic                          top,
    output logic                          bottom,
    output logic [11:0]                   random,
    input  logic                          final_spin_val,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   sweep_count,
    output logic signed [2*SIDE_LOG2+1:0] magnetization
);

    localparam int L  = 1 << SIDE_LOG2;
    localparam int N  = L * L;
    localparam int AW = 2 * SIDE_LOG2;
    localparam int MW = AW + 2;
    localparam logic [31:0]           LFSR_TAPS = 32'h80200003;
    localparam logic [31:0]           SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic signed [MW-1:0]  MAG_INIT  = (INIT_SPIN != 0) ? MW'(N) : MW'(-N);
    localparam logic [SIDE_LOG2-1:0]  XMAX      = SIDE_LOG2'(L - 1);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t                 state_q;
    logic [N-1:0]           lattice_q, lattice_d;
    logic [SIDE_LOG2-1:0]   x_q, y_q, x_d, y_d;
    logic [SIDE_LOG2-1:0]   xm1, xp1, ym1, yp1;
    logic [15:0]            sweep_q, nsweeps_q;
    logic [31:0]            lfsr_q;
    logic signed [MW-1:0]   mag_q, mag_d;
    logic                   busy_q, done_q;
    logic                   wr_act, wr_val;
    logic [AW-1:0]          wr_addr;
    logic                   last_site;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Neighbour addresses wrap naturally in SIDE_LOG2 bits, giving periodic boundaries.
    assign xm1 = x_q - SIDE_LOG2'(1);
    assign xp1 = x_q + SIDE_LOG2'(1);
    assign ym1 = y_q - SIDE_LOG2'(1);
    assign yp1 = y_q + SIDE_LOG2'(1);

    assign rd_spin       = lattice_q[{rd_y, rd_x}];
    assign spin_val      = lattice_q[{y_q, x_q}];
    assign left          = lattice_q[{y_q, xm1}];
    assign right         = lattice_q[{y_q, xp1}];
    assign top           = lattice_q[{ym1, x_q}];
    assign bottom        = lattice_q[{yp1, x_q}];
    assign random        = lfsr_q[11:0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign sweep_count   = sweep_q;
    assign magnetization = mag_q;

    assign last_site = (x_q == XMAX) && (y_q == XMAX);

    // One shared write port: the spin stage owns it while sweeping, the preload port in IDLE.
    always_comb begin
        wr_act    = 1'b0;
        wr_addr   = {y_q, x_q};
        wr_val    = final_spin_val;
        lattice_d = lattice_q;
        mag_d     = mag_q;
        x_d       = xp1;
        y_d       = (x_q == XMAX) ? yp1 : y_q;
        if (state_q == UPDATE) begin
            wr_act = 1'b1;
        end else if (state_q == IDLE && wr_en) begin
            wr_act  = 1'b1;
            wr_addr = {wr_y, wr_x};
            wr_val  = wr_spin;
        end
        if (wr_act) begin
            lattice_d[wr_addr] = wr_val;
            if (lattice_q[wr_addr] != wr_val)
                mag_d = wr_val ? mag_q + MW'(2) : mag_q - MW'(2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lattice_q <= {N{INIT_SPIN != 0}};
            x_q       <= '0;
            y_q       <= '0;
            sweep_q   <= '0;
            nsweeps_q <= '0;
            lfsr_q    <= SEED_EFF;
            mag_q     <= MAG_INIT;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            lattice_q <= lattice_d;
            mag_q     <= mag_d;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sweep_q   <= '0;
                        nsweeps_q <= num_sweeps;
                        x_q       <= '0;
                        y_q       <= '0;
                        if (num_sweeps != 16'd0) begin
                            state_q <= UPDATE;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    lfsr_q <= lfsr_step(lfsr_q);
                    x_q    <= x_d;
                    y_q    <= y_d;
                    if (last_site) begin
                        sweep_q <= sweep_q + 16'd1;
                        if (sweep_q + 16'd1 == nsweeps_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ising_lattice_sweeper.sv
// Randomised bench for ising_lattice_sweeper against an array-based lattice model.
module tb_ising_lattice_sweeper;

    localparam int SL = 3;
    localparam int L  = 1 << SL;
    localparam int N  = L * L;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [15:0]        num_sweeps = '0;
    logic               wr_en = 1'b0;
    logic [SL-1:0]      wr_x = '0, wr_y = '0;
    logic               wr_spin = 1'b0;
    logic [SL-1:0]      rd_x = '0, rd_y = '0;
    logic               rd_spin, spin_val, left, right, top, bottom;
    logic [11:0]        random;
    logic               final_spin_val = 1'b0;
    logic               busy, done;
    logic [15:0]        sweep_count;
    logic signed [2*SL+1:0] magnetization;

    int vec_cnt = 0;
    int err_cnt = 0;

    bit          m [L][L];
    int          px, py, swp;
    logic [31:0] lfsr_m;

    ising_lattice_sweeper #(.SIDE_LOG2(SL), .INIT_SPIN(1), .SEED(32'hACE12468)) dut (
        .clk(clk), .reset(reset), .start(start), .num_sweeps(num_sweeps),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_spin(wr_spin),
        .rd_x(rd_x), .rd_y(rd_y), .rd_spin(rd_spin),
        .spin_val(spin_val), .left(left), .right(right), .top(top), .bottom(bottom),
        .random(random), .final_spin_val(final_spin_val),
        .busy(busy), .done(done), .sweep_count(sweep_count), .magnetization(magnetization)
    );

    always #5 clk = ~clk;

    function automatic int mag_model();
        int s = 0;
        for (int y = 0; y < L; y++)
            for (int x = 0; x < L; x++)
                s += m[y][x] ? 1 : -1;
        return s;
    endfunction

    function automatic void model_reset();
        for (int y = 0; y < L; y++)
            for (int x = 0; x < L; x++)
                m[y][x] = 1'b1;
        px = 0; py = 0; swp = 0;
        lfsr_m = 32'hACE12468;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; wr_en = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // mode: 0 invert, 1 keep, 2 random spin; meddle_at drives start/wr_en mid-run; reset_at aborts.
    task automatic run(input int s, input int mode, input int meddle_at, input int reset_at);
        logic [33:0] exp_v, act_v;
        bit fv;
        bit meddle = 0;
        start = 1'b1; num_sweeps = 16'(s);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; num_sweeps = 16'($urandom_range(1, 9));
        px = 0; py = 0; swp = 0;
        for (int k = 0; k < s * N; k++) begin
            if (k == reset_at) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0; start = 1'b0; wr_en = 1'b0;
                model_reset();
                vec_cnt++;
                if ({busy, done, sweep_count, random, spin_val} !== {1'b0, 1'b0, 16'd0, 12'h468, 1'b1}) begin
                    err_cnt++;
                    $display("FAIL reset_mid: got busy=%b done=%b sweeps=%0d rnd=%h spin=%b, want 0 0 0 468 1",
                             busy, done, sweep_count, random, spin_val);
                end
                vec_cnt++;
                if (int'(magnetization) !== 64) begin
                    err_cnt++;
                    $display("FAIL reset_mid_mag: got %0d want 64", magnetization);
                end
                return;
            end
            if (k == meddle_at) meddle = 1;
            if (meddle) begin
                start = 1'b1; num_sweeps = 16'd7; wr_en = 1'b1;
                wr_x = SL'($urandom); wr_y = SL'($urandom); wr_spin = 1'($urandom);
            end
            exp_v = {1'b1, m[py][px], m[py][(px+L-1)%L], m[py][(px+1)%L],
                     m[(py+L-1)%L][px], m[(py+1)%L][px], lfsr_m[11:0], 16'(swp)};
            act_v = {busy, spin_val, left, right, top, bottom, random, sweep_count};
            vec_cnt++;
            if (act_v !== exp_v) begin
                err_cnt++;
                $display("FAIL cycle%0d site(%0d,%0d): got %h want %h", k, px, py, act_v, exp_v);
            end
            vec_cnt++;
            if (int'(magnetization) !== mag_model()) begin
                err_cnt++;
                $display("FAIL cycle%0d_mag: got %0d want %0d", k, magnetization, mag_model());
            end
            case (mode)
                0: fv = ~m[py][px];
                1: fv = m[py][px];
                default: fv = 1'($urandom);
            endcase
            final_spin_val = fv;
            @(posedge clk);
            m[py][px] = fv;
            lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 32'h80200003 : 32'h0);
            px++;
            if (px == L) begin
                px = 0; py++;
                if (py == L) begin py = 0; swp++; end
            end
            @(negedge clk);
        end
        start = 1'b0; wr_en = 1'b0;
        vec_cnt++;
        if ({done, busy, sweep_count} !== {1'b1, 1'b0, 16'(s)}) begin
            err_cnt++;
            $display("FAIL run_end: got done=%b busy=%b sweeps=%0d want 1 0 %0d", done, busy, sweep_count, s);
        end
        vec_cnt++;
        if (int'(magnetization) !== mag_model()) begin
            err_cnt++;
            $display("FAIL run_end_mag: got %0d want %0d", magnetization, mag_model());
        end
        @(negedge clk);
        vec_cnt++;
        if ({done, busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL run_idle: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int a = 0; a < N; a++) begin
            rd_x = SL'(a % L); rd_y = SL'(a / L);
            #1;
            vec_cnt++;
            if (rd_spin !== 1'b1) begin
                err_cnt++;
                $display("FAIL reset_rd(%0d,%0d): got %b want 1", rd_x, rd_y, rd_spin);
            end
        end
        vec_cnt++;
        if ({busy, done, random, spin_val, left, right, top, bottom} !== {2'b00, 12'h468, 5'b11111}) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got busy=%b done=%b rnd=%h nb=%b", busy, done, random,
                     {spin_val, left, right, top, bottom});
        end
        vec_cnt++;
        if (int'(magnetization) !== 64) begin
            err_cnt++;
            $display("FAIL reset_mag: got %0d want 64", magnetization);
        end
    endtask

    task automatic test_invert();
        run(1, 0, -1, -1);
        for (int a = 0; a < N; a++) begin
            rd_x = SL'(a % L); rd_y = SL'(a / L);
            #1;
            vec_cnt++;
            if (rd_spin !== 1'b0) begin
                err_cnt++;
                $display("FAIL invert_rd(%0d,%0d): got %b want 0", rd_x, rd_y, rd_spin);
            end
        end
        vec_cnt++;
        if (int'(magnetization) !== -64) begin
            err_cnt++;
            $display("FAIL invert_mag: got %0d want -64", magnetization);
        end
        @(negedge clk);
    endtask

    task automatic test_identity();
        do_reset();
        run(3, 1, -1, -1);
        vec_cnt++;
        if (int'(magnetization) !== 64 || random !== lfsr_m[11:0]) begin
            err_cnt++;
            $display("FAIL identity: got mag=%0d rnd=%h want 64 %h", magnetization, random, lfsr_m[11:0]);
        end
    endtask

    task automatic test_zero();
        start = 1'b1; num_sweeps = 16'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        vec_cnt++;
        if ({done, busy, sweep_count, random} !== {1'b1, 1'b0, 16'd0, lfsr_m[11:0]}) begin
            err_cnt++;
            $display("FAIL zero_sweeps: got done=%b busy=%b sweeps=%0d rnd=%h want 1 0 0 %h",
                     done, busy, sweep_count, random, lfsr_m[11:0]);
        end
        @(negedge clk);
        vec_cnt++;
        if ({done, busy, random} !== {2'b00, lfsr_m[11:0]}) begin
            err_cnt++;
            $display("FAIL zero_after: got done=%b busy=%b rnd=%h", done, busy, random);
        end
    endtask

    task automatic test_preload();
        do_reset();
        wr_en = 1'b1; wr_x = 3'd7; wr_y = 3'd0; wr_spin = 1'b0;
        @(posedge clk); m[0][7] = 1'b0;
        @(negedge clk);
        wr_x = 3'd0; wr_y = 3'd7;
        @(posedge clk); m[7][0] = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        vec_cnt++;
        if (int'(magnetization) !== 60) begin
            err_cnt++;
            $display("FAIL preload_mag: got %0d want 60", magnetization);
        end
        vec_cnt++;
        if ({spin_val, left, top, right, bottom} !== 5'b10011) begin
            err_cnt++;
            $display("FAIL preload_nb: got s,l,t,r,b=%b want 10011", {spin_val, left, top, right, bottom});
        end
        run(1, 2, -1, -1);
    endtask

    task automatic test_busy_ignore();
        run(1, 2, 10, -1);
    endtask

    task automatic test_reset_mid();
        run(2, 2, -1, N + 20);
        for (int a = 0; a < N; a++) begin
            rd_x = SL'(a % L); rd_y = SL'(a / L);
            #1;
            vec_cnt++;
            if (rd_spin !== 1'b1) begin
                err_cnt++;
                $display("FAIL reset_mid_rd(%0d,%0d): got %b want 1", rd_x, rd_y, rd_spin);
            end
        end
        @(negedge clk);
        run(1, 2, -1, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_x = SL'($urandom); wr_y = SL'($urandom); wr_spin = 1'($urandom);
            @(posedge clk); m[wr_y][wr_x] = wr_spin;
            @(negedge clk);
        end
        wr_en = 1'b0;
        run(2, 2, -1, -1);
        for (int a = 0; a < N; a++) begin
            rd_x = SL'(a % L); rd_y = SL'(a / L);
            #1;
            vec_cnt++;
            if (rd_spin !== m[a / L][a % L]) begin
                err_cnt++;
                $display("FAIL random_rd(%0d,%0d): got %b want %b", rd_x, rd_y, rd_spin, m[a / L][a % L]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_invert();
        test_identity();
        test_zero();
        test_preload();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ising_lattice_sweeper.md
# ising_lattice_sweeper

Sequencer and spin store for the Metropolis Ising core. Holds an L×L lattice of one-bit spins with periodic boundaries. Visits every site in raster order and presents the site and its four neighbours, plus a 12-bit uniform random value, to the downstream spin-update stage. Writes the returned spin back into the lattice and tracks magnetization and completed sweeps.

## Interface
Parameters:
- SIDE_LOG2, 3: lattice side L = 2^SIDE_LOG2; N = L*L sites.
- INIT_SPIN, 1: value loaded into every site on reset (1 = +1, 0 = −1).
- SEED, 32'hACE12468: LFSR reset value. If SEED = 0, the LFSR loads 32'h1 instead.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  launch a run; sampled only in IDLE.
- num_sweeps  in  16  full-lattice sweeps per run; sampled with start.
- wr_en, wr_x, wr_y, wr_spin  in  1/SIDE_LOG2/SIDE_LOG2/1  lattice preload; honoured only in IDLE.
- rd_x, rd_y  in  SIDE_LOG2 each  read address.
- rd_spin  out  1  combinational lattice[rd_y][rd_x].
- spin_val, left, right, top, bottom  out  1 each  current site and neighbours, to the spin stage.
- random  out  12  LFSR[11:0], to the spin stage.
- final_spin_val  in  1  updated spin from the spin stage (combinational path).
- busy  out  1  high in UPDATE.
- done  out  1  one-cycle pulse at run end.
- sweep_count  out  16  sweeps completed in current/last run.
- magnetization  out  2*SIDE_LOG2+2  signed sum of spins (±1 each).

## Operation
- FSM has three states: IDLE, UPDATE, DONE.
  - IDLE→UPDATE on start when num_sweeps ≠ 0. This clears sweep_count and sets x = y = 0.
  - IDLE→DONE on start when num_sweeps = 0.
  - UPDATE→DONE after the last site of the last sweep.
  - DONE→IDLE unconditionally.
- Site order: x increments fastest (0..L−1), then y. After (L−1, L−1), the position wraps to (0,0) and sweep_count increments.
- Neighbours use mod-L arithmetic (natural SIDE_LOG2-bit wrap):
  - left = (x−1, y), right = (x+1, y)
  - top = (x, y−1), bottom = (x, y+1)
- Neighbour and spin outputs are combinational from the lattice at the current (x, y). They are valid in all states; in IDLE they show site (x, y) as last left.
- Each UPDATE cycle does the following on the clock edge:
  - lattice[y][x] ← final_spin_val;
  - magnetization changes by +2 if the site flips 0→1 and by −2 if it flips 1→0, otherwise is unchanged;
  - LFSR steps once;
  - the position advances.
- LFSR is 32-bit Galois, shifting right: s ← (s>>1) ^ (s[0] ? 32'h80200003 : 0). It steps only in UPDATE cycles.
- Preload in IDLE: lattice[wr_y][wr_x] ← wr_spin, and magnetization is adjusted ±2 if the stored value changes. wr_en is ignored outside IDLE.
- start is ignored outside IDLE. num_sweeps is latched at start; later changes have no effect.

## Timing
- Reset values:
  - state IDLE; busy 0; done 0; sweep_count 0; x = y = 0;
  - all sites = INIT_SPIN;
  - magnetization = +N if INIT_SPIN, else −N;
  - LFSR = SEED (or 1).
  - Outputs follow: spin/neighbour outputs = INIT_SPIN; random = SEED[11:0].
- Reset in any state, including mid-sweep, restores all reset values on that edge; no partial run resumes.
- Start sampled at edge E0: busy = 1 from E0. The first site write happens at E1.
- A run of S sweeps takes exactly S*N UPDATE cycles. After the final write edge: done = 1 for one cycle, busy = 0, sweep_count = S. Then the block returns to IDLE.
- With num_sweeps = 0: done pulses the cycle after start. There are no writes, the LFSR does not step, and sweep_count = 0.
- Throughput is one site per clock.
- The final_spin_val → lattice path is single-cycle combinational through the spin stage; the spin stage must close timing within one clk period.

## Test plan
- Reset with INIT_SPIN = 1, L = 8: rd_spin = 1 at all 64 addresses, magnetization = +64, random = 12'h468, busy = 0, done = 0.
- Stub final_spin_val = ~spin_val, start with num_sweeps = 1: busy high for exactly 64 cycles, then done for 1 cycle. Result: all sites 0, magnetization = −64, sweep_count = 1.
- Stub final_spin_val = spin_val, num_sweeps = 3: lattice unchanged, magnetization = +64. 192 LFSR steps are seen on random, matching the Galois reference sequence from 32'hACE12468.
- Preload only (7,0) = 0 and (0,7) = 0, then start: in the first UPDATE cycle (site (0,0)), left = 0, top = 0, right = 1, bottom = 1. Magnetization before start = +60.
- Assert start and wr_en while busy: no restart, no lattice write from the preload port. Run completes with the original num_sweeps.
- Assert reset at cycle 20 of a sweep: next cycle all reset values hold and busy = 0. A new start then runs cleanly from (0,0).
